// File: rtl/mult_div_unit_if.sv
// Request/response bundle between MIPS control and the multiply/divide sequencer.
// The master side issues operations and MTHI/MTLO writes; the slave side returns HI/LO and status.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] OpA;
    logic [WIDTH-1:0] OpB;
    logic             hi_load;
    logic             lo_load;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             busy;
    logic             done;
    logic             div_zero;

    modport master (
        output start, op, OpA, OpB, hi_load, lo_load, wdata,
        input  HI, LO, busy, done, div_zero
    );

    modport slave (
        input  start, op, OpA, OpB, hi_load, lo_load, wdata,
        output HI, LO, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO; result lands WIDTH+1 edges after start.
// No backpressure: start is taken only in IDLE and dropped while busy; caller stalls on busy/done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               reset,
    mult_div_unit_if.slave     bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_a;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;

    logic               w_signed_in;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rmd;

    // op[0]=0 selects the signed variants; magnitudes are run through an unsigned core
    assign w_signed_in = ~bus.op[0];
    assign w_a_neg     = w_signed_in & bus.OpA[WIDTH-1];
    assign w_b_neg     = w_signed_in & bus.OpB[WIDTH-1];
    assign w_a_mag     = w_a_neg ? (~bus.OpA + 1'b1) : bus.OpA;
    assign w_b_mag     = w_b_neg ? (~bus.OpB + 1'b1) : bus.OpB;

    assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_a};
    assign w_rem  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff = w_rem - {1'b0, r_a};

    always_comb begin
        w_acc_next = r_acc;
        if (r_is_div) begin
            // Restoring step: keep the shifted remainder when the trial subtract goes negative
            if (w_diff[WIDTH]) begin
                w_acc_next = {w_rem[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
            end else begin
                w_acc_next = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (r_acc[0]) begin
                w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
            end else begin
                w_acc_next = {1'b0, r_acc[2*WIDTH-1:1]};
            end
        end
    end

    assign w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    assign w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    assign w_rmd  = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_a      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        if (bus.op[1] && (bus.OpB == '0)) begin
                            r_done <= 1'b1;
                            r_dz   <= 1'b1;
                        end else begin
                            r_is_div <= bus.op[1];
                            r_neg_q  <= w_a_neg ^ w_b_neg;
                            r_neg_r  <= w_a_neg;
                            if (bus.op[1]) begin
                                r_a   <= w_b_mag;
                                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                            end else begin
                                r_a   <= w_a_mag;
                                r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                            end
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end else begin
                        if (bus.hi_load) r_hi <= bus.wdata;
                        if (bus.lo_load) r_lo <= bus.wdata;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rmd;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.HI       = r_hi;
    assign bus.LO       = r_lo;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.div_zero = r_dz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: stimulus pushes expected HI/LO/div_zero into a queue,
// a negedge monitor pops and compares on every done pulse.
module tb_mult_div_unit;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic Clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];

    mult_div_unit_if #(.WIDTH(32)) bus ();

    mult_div_unit #(.WIDTH(32)) dut (
        .Clk   (Clk),
        .reset (reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge Clk) begin
        if (bus.done === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: actual HI=%h LO=%h dz=%b required no done", bus.HI, bus.LO, bus.div_zero);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.HI !== e.hi || bus.LO !== e.lo || bus.div_zero !== e.dz) begin
                    errors++;
                    $display("FAIL result: actual HI=%h LO=%h dz=%b required HI=%h LO=%h dz=%b",
                             bus.HI, bus.LO, bus.div_zero, e.hi, e.lo, e.dz);
                end
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_result(input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        e.dz = dz;
        exp_q.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.OpA   = a;
        bus.OpB   = b;
        tick();
        bus.start = 1'b0;
        bus.OpA   = $urandom;
        bus.OpB   = $urandom;
    endtask

    // Counts edges from now until done; busy must hold high throughout and drop with done
    task automatic wait_done(input int exp_edges, input string name);
        int n;
        bit busy_ok;
        n = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && n < exp_edges + 10) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(exp_edges));
        check({name, "_busy_window"}, 64'(busy_ok), 64'd1);
        check({name, "_busy_low_at_done"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.OpA = '0;
        bus.OpB = '0;
        bus.hi_load = 1'b0;
        bus.lo_load = 1'b0;
        bus.wdata = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset_hi", 64'(bus.HI), 64'd0);
        check("reset_lo", 64'(bus.LO), 64'd0);
        check("reset_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'd0);
        tick();

        // MULT -3 * 7 = -21
        expect_result(32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        issue(2'b00, 32'hFFFFFFFD, 32'd7);
        wait_done(33, "mult_neg");

        // MULTU max*max, then DIVU issued in the done cycle
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
        expect_result(32'hFFFFFFFE, 32'h00000001, 1'b0);
        wait_done(33, "multu_max");
        expect_result(32'd2, 32'd14, 1'b0);
        issue(2'b11, 32'd100, 32'd7);
        check("b2b_busy_rise", 64'(bus.busy), 64'd1);
        wait_done(33, "divu_100_7");

        expect_result(32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        issue(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(33, "div_neg7_2");

        expect_result(32'h00000000, 32'h80000000, 1'b0);
        issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(33, "div_overflow");
        tick();

        // MTHI/MTLO then divide by zero
        bus.hi_load = 1'b1;
        bus.lo_load = 1'b1;
        bus.wdata = 32'h12345678;
        tick();
        bus.hi_load = 1'b0;
        bus.lo_load = 1'b0;
        check("mthi", 64'(bus.HI), 64'h12345678);
        check("mtlo", 64'(bus.LO), 64'h12345678);
        expect_result(32'h12345678, 32'h12345678, 1'b1);
        issue(2'b10, 32'd55, 32'd0);
        check("dz_flags", {61'd0, bus.busy, bus.done, bus.div_zero}, 64'b011);
        tick();
        check("dz_pulse_width", {62'd0, bus.done, bus.div_zero}, 64'd0);
        check("dz_busy_idle", 64'(bus.busy), 64'd0);

        // Start, MTHI and MTLO during a run are all ignored
        expect_result(32'd0, 32'd30, 1'b0);
        issue(2'b00, 32'd5, 32'd6);
        repeat (9) tick();
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.OpA = 32'd1000;
        bus.OpB = 32'd3;
        bus.hi_load = 1'b1;
        bus.lo_load = 1'b1;
        bus.wdata = 32'hDEADBEEF;
        tick();
        bus.start = 1'b0;
        bus.hi_load = 1'b0;
        bus.lo_load = 1'b0;
        check("run_hi_hold", 64'(bus.HI), 64'h12345678);
        wait_done(23, "mult_5_6");
        repeat (40) tick();

        // Reset mid-divide aborts with no done pulse
        issue(2'b10, 32'd100, 32'd3);
        repeat (14) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_hi", 64'(bus.HI), 64'd0);
        check("abort_lo", 64'(bus.LO), 64'd0);
        check("abort_flags", {62'd0, bus.busy, bus.done}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("abort_no_done", 64'(saw_done), 64'd0);

        expect_result(32'd0, 32'd6, 1'b0);
        issue(2'b00, 32'd2, 32'd3);
        wait_done(33, "mult_2_3");
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
